tile_fill: RTL and testbench

TILE_FILL -- requirements
Module: tile_fill

---
 rtl/vga_pkg.sv | 29 ++
 rtl/tile_fill_if.sv | 34 +++
 rtl/tile_addr_gen.sv | 66 ++++++
 rtl/tile_fill.sv | 121 ++++++++++++
 tb/tb_tile_fill.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the tile-memory side of the VGA path.
//   COLS_DEF / ROWS_DEF : default tile grid (80 x 60)
//   ADDR_W              : tile memory address width (13 bits covers 4800 tiles)
//   fill_state_t        : tile_fill controller states
//   row_offset()        : row*cols built from shifts and adds of a constant
package vga_pkg;

  localparam int unsigned COLS_DEF = 80;
  localparam int unsigned ROWS_DEF = 60;
  localparam int unsigned ADDR_W   = 13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FINISH
  } fill_state_t;

  // Constant-coefficient product: with a fixed cols this reduces to a few adders.
  function automatic logic [ADDR_W-1:0] row_offset(input logic [5:0] row,
                                                   input int unsigned cols);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      if (cols[i]) acc = acc + (ADDR_W'(row) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/tile_fill_if.sv
// tile_fill_if: command handshake plus tile-memory write port of tile_fill.
//   CMD_VALID/CMD_READY : command handshake
//   CMD_X/Y/W/H         : rectangle origin and size in tiles
//   CMD_COLOR           : RRRGGGBB fill colour
//   WE/WADDR/WDATA      : write port into the tile memory
//   BUSY/DONE/ERR       : status (DONE and ERR are one-cycle pulses)
// Modports: master = command source / memory sink, slave = tile_fill.
interface tile_fill_if;
  import vga_pkg::*;

  logic              CMD_VALID;
  logic              CMD_READY;
  logic [6:0]        CMD_X;
  logic [5:0]        CMD_Y;
  logic [6:0]        CMD_W;
  logic [5:0]        CMD_H;
  logic [7:0]        CMD_COLOR;
  logic              WE;
  logic [ADDR_W-1:0] WADDR;
  logic [7:0]        WDATA;
  logic              BUSY;
  logic              DONE;
  logic              ERR;

  modport master (
    output CMD_VALID, CMD_X, CMD_Y, CMD_W, CMD_H, CMD_COLOR,
    input  CMD_READY, WE, WADDR, WDATA, BUSY, DONE, ERR
  );

  modport slave (
    input  CMD_VALID, CMD_X, CMD_Y, CMD_W, CMD_H, CMD_COLOR,
    output CMD_READY, WE, WADDR, WDATA, BUSY, DONE, ERR
  );
endinterface

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: row-major address walker for a tile rectangle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load origin (x, y) and size (w, h); w and h must be non-zero
//   step       : advance to the next tile
//   addr       : registered address of the current tile
//   last       : current tile is the final one of the rectangle
// Addresses advance by +1 per column and by +cols per row; no multiplier.
module tile_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [6:0]        x,
  input  logic [5:0]        y,
  input  logic [6:0]        w,
  input  logic [5:0]        h,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  logic [6:0]        w_lat;
  logic [6:0]        col_left;
  logic [5:0]        row_left;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] base0;

  always_comb begin
    base0 = row_offset(y, COLS) + ADDR_W'(x);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_lat    <= '0;
      col_left <= '0;
      row_left <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (start) begin
      w_lat    <= w;
      col_left <= w - 7'd1;
      row_left <= h - 6'd1;
      row_base <= base0;
      addr     <= base0;
    end else if (step) begin
      if (col_left == '0) begin
        // end of row: jump to the start of the next row
        row_base <= row_base + COLS_A;
        addr     <= row_base + COLS_A;
        col_left <= w_lat - 7'd1;
        row_left <= row_left - 6'd1;
      end else begin
        addr     <= addr + 1'b1;
        col_left <= col_left - 7'd1;
      end
    end
  end

  assign last = (col_left == '0) && (row_left == '0);

endmodule

// File: rtl/tile_fill.sv
// tile_fill: fills a rectangle of the tile memory with one colour.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus          : tile_fill_if.slave (command handshake, write port, status)
// A command is accepted on CMD_VALID && CMD_READY; writes start the next cycle,
// one per cycle in row-major order, followed by a one-cycle DONE pulse during
// which a new command may already be accepted.
// Build option TILE_FILL_CLIP_EN: clamp rectangles to the screen instead of
// rejecting out-of-range commands with an ERR pulse.
module tile_fill
  import vga_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned ROWS = ROWS_DEF
) (
  input  logic      CLK,
  input  logic      RESET_N,
  tile_fill_if.slave bus
);

  localparam logic [7:0] COLS8 = COLS[7:0];
  localparam logic [6:0] ROWS7 = ROWS[6:0];

  fill_state_t state;
  logic        ready_q, we_q, busy_q, done_q, err_q;
  logic [7:0]  wdata_q;

  logic [7:0]  x_end;
  logic [6:0]  y_end;
  logic [6:0]  eff_w;
  logic [5:0]  eff_h;
  logic        cmd_bad, accept, zero_area, start, step, last;

  always_comb begin
    x_end = {1'b0, bus.CMD_X} + {1'b0, bus.CMD_W};
    y_end = {1'b0, bus.CMD_Y} + {1'b0, bus.CMD_H};
`ifdef TILE_FILL_CLIP_EN
    cmd_bad = 1'b0;
    if ({1'b0, bus.CMD_X} >= COLS8)  eff_w = '0;
    else if (x_end > COLS8)          eff_w = 7'(COLS8 - {1'b0, bus.CMD_X});
    else                             eff_w = bus.CMD_W;
    if ({1'b0, bus.CMD_Y} >= ROWS7)  eff_h = '0;
    else if (y_end > ROWS7)          eff_h = 6'(ROWS7 - {1'b0, bus.CMD_Y});
    else                             eff_h = bus.CMD_H;
`else
    cmd_bad = (x_end > COLS8) || (y_end > ROWS7);
    eff_w   = bus.CMD_W;
    eff_h   = bus.CMD_H;
`endif
    accept    = bus.CMD_VALID && ready_q;
    zero_area = (eff_w == '0) || (eff_h == '0);
    start     = accept && !cmd_bad && !zero_area;
    step      = (state == ST_FILL) && !last;
  end

  tile_addr_gen #(.COLS(COLS)) u_addr_gen (
    .clk   (CLK),
    .rst_n (RESET_N),
    .start (start),
    .step  (step),
    .x     (bus.CMD_X),
    .y     (bus.CMD_Y),
    .w     (eff_w),
    .h     (eff_h),
    .addr  (bus.WADDR),
    .last  (last)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (last) begin
            state   <= ST_FINISH;
            we_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        // IDLE and FINISH both accept commands; FINISH is the DONE cycle.
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          if (accept) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else if (zero_area) begin
              done_q <= 1'b1;
              state  <= ST_FINISH;
            end else begin
              state   <= ST_FILL;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
              wdata_q <= bus.CMD_COLOR;
              busy_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.CMD_READY = ready_q;
  assign bus.WE        = we_q;
  assign bus.WDATA     = wdata_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_tile_fill.sv
module tb_tile_fill;
  localparam int COLS = 80;
  localparam int ROWS = 60;

  logic CLK = 1'b0;
  logic RESET_N;
  int   total = 0;
  int   bad   = 0;
  int unsigned exp_q[$];

  tile_fill_if bus();

  tile_fill #(.COLS(COLS), .ROWS(ROWS)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list every tile address the rectangle should cover.
  task automatic build_model(input int x, input int y, input int w, input int h,
                             output bit err);
    int ew, eh;
    exp_q.delete();
    err = 1'b0;
`ifdef TILE_FILL_CLIP_EN
    ew = (x >= COLS) ? 0 : ((x + w > COLS) ? COLS - x : w);
    eh = (y >= ROWS) ? 0 : ((y + h > ROWS) ? ROWS - y : h);
`else
    if (x + w > COLS || y + h > ROWS) err = 1'b1;
    ew = err ? 0 : w;
    eh = err ? 0 : h;
`endif
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++)
        exp_q.push_back(int'((y + r) * COLS + x + c));
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic send(input int x, input int y, input int w, input int h,
                      input logic [7:0] color);
    chk("ready_pre", {31'd0, bus.CMD_READY}, 32'd1);
    bus.CMD_X     = 7'(x);
    bus.CMD_Y     = 6'(y);
    bus.CMD_W     = 7'(w);
    bus.CMD_H     = 6'(h);
    bus.CMD_COLOR = color;
    bus.CMD_VALID = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic scramble();
    bus.CMD_VALID = 1'b0;
    bus.CMD_X     = 7'($urandom);
    bus.CMD_Y     = 6'($urandom);
    bus.CMD_W     = 7'($urandom);
    bus.CMD_H     = 6'($urandom);
    bus.CMD_COLOR = 8'($urandom);
  endtask

  // Checks the write stream, ends in the DONE/ERR cycle.
  task automatic expect_cmd(input string tag, input logic [7:0] color, input bit err);
    foreach (exp_q[i]) begin
      chk({tag, ".we"},    {31'd0, bus.WE},        32'd1);
      chk({tag, ".waddr"}, {19'd0, bus.WADDR},     exp_q[i]);
      chk({tag, ".wdata"}, {24'd0, bus.WDATA},     {24'd0, color});
      chk({tag, ".busy"},  {31'd0, bus.BUSY},      32'd1);
      chk({tag, ".ready"}, {31'd0, bus.CMD_READY}, 32'd0);
      chk({tag, ".done"},  {31'd0, bus.DONE},      32'd0);
      @(posedge CLK); #1;
    end
    chk({tag, ".end_done"},  {31'd0, bus.DONE},      {31'd0, !err});
    chk({tag, ".end_err"},   {31'd0, bus.ERR},       {31'd0, err});
    chk({tag, ".end_we"},    {31'd0, bus.WE},        32'd0);
    chk({tag, ".end_busy"},  {31'd0, bus.BUSY},      32'd0);
    chk({tag, ".end_ready"}, {31'd0, bus.CMD_READY}, 32'd1);
    chk({tag, ".end_wdata"}, {24'd0, bus.WDATA},     32'd0);
  endtask

  task automatic run(input string tag, input int x, input int y, input int w,
                     input int h, input logic [7:0] color);
    bit err;
    build_model(x, y, w, h, err);
    send(x, y, w, h, color);
    scramble();
    expect_cmd(tag, color, err);
  endtask

  initial begin
    bit err;
    RESET_N = 1'b0;
    bus.CMD_VALID = 1'b0;
    bus.CMD_X = '0; bus.CMD_Y = '0; bus.CMD_W = '0; bus.CMD_H = '0;
    bus.CMD_COLOR = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst.ready", {31'd0, bus.CMD_READY}, 32'd0);
    chk("rst.we",    {31'd0, bus.WE},        32'd0);
    chk("rst.waddr", {19'd0, bus.WADDR},     32'd0);
    chk("rst.wdata", {24'd0, bus.WDATA},     32'd0);
    chk("rst.busy",  {31'd0, bus.BUSY},      32'd0);
    chk("rst.done",  {31'd0, bus.DONE},      32'd0);
    chk("rst.err",   {31'd0, bus.ERR},       32'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // directed corner cases
    run("sq2x2",   0,  0, 2, 2, 8'hE0);
    run("corner", 79, 59, 1, 1, 8'h1F);
    run("w0",      3,  4, 0, 5, 8'h55);
    run("h0",      3,  4, 5, 0, 8'h55);
    run("edge",   78,  0, 4, 1, 8'hA5);
    run("ybeyond", 0, 58, 2, 3, 8'h3C);
    run("xoff",   90, 10, 2, 2, 8'hC3);

    // back-to-back with CMD_VALID held high
    build_model(10, 3, 3, 2, err);
    send(10, 3, 3, 2, 8'h1C);
    bus.CMD_X = 7'd5; bus.CMD_Y = 6'd7; bus.CMD_W = 7'd2; bus.CMD_H = 6'd1;
    bus.CMD_COLOR = 8'h03;
    expect_cmd("b2b_a", 8'h1C, err);
    @(posedge CLK); #1;
    scramble();
    build_model(5, 7, 2, 1, err);
    expect_cmd("b2b_b", 8'h03, err);

    // randomized commands
    for (int n = 0; n < 30; n++) begin
      int x, y, w, h;
      logic [7:0] c;
      x = int'($urandom_range(0, 88));
      y = int'($urandom_range(0, 63));
      w = int'($urandom_range(0, 9));
      h = int'($urandom_range(0, 5));
      c = 8'($urandom);
      run($sformatf("rnd%0d", n), x, y, w, h, c);
    end

    // reset during the 3rd write of a 10x1 fill
    build_model(20, 5, 10, 1, err);
    send(20, 5, 10, 1, 8'hFF);
    scramble();
    for (int i = 0; i < 3; i++) begin
      chk("rstmid.we",    {31'd0, bus.WE},    32'd1);
      chk("rstmid.waddr", {19'd0, bus.WADDR}, exp_q[i]);
      if (i < 2) begin
        @(posedge CLK); #1;
      end
    end
    #2 RESET_N = 1'b0;
    #1;
    chk("rstmid.async_we",   {31'd0, bus.WE},        32'd0);
    chk("rstmid.async_busy", {31'd0, bus.BUSY},      32'd0);
    chk("rstmid.async_rdy",  {31'd0, bus.CMD_READY}, 32'd0);
    repeat (2) begin
      @(posedge CLK); #1;
      chk("rstmid.hold_we",   {31'd0, bus.WE},   32'd0);
      chk("rstmid.hold_done", {31'd0, bus.DONE}, 32'd0);
    end
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("rstmid.post_ready", {31'd0, bus.CMD_READY}, 32'd1);
      chk("rstmid.post_we",    {31'd0, bus.WE},        32'd0);
      chk("rstmid.post_done",  {31'd0, bus.DONE},      32'd0);
    end

    run("after_rst", 0, 1, 3, 1, 8'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
